// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

endpackage : fetch_pkg

// File: rtl/fetch_fsm.sv
// Fetch sequencer: state register, stale-fetch kill flag, and the strobes
// that steer the pc/target/output registers held in the top level.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | out of reset, nothing issued; redirects ignored
//   REQ   | imem_req high at pc; waiting for imem_ack
//   HOLD  | instruction presented to decode; waiting for instr_ready
module fetch_fsm
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         imem_ack_i,
  input  logic         redirect_i,
  input  logic         instr_ready_i,
  output fetch_state_t state_o,
  output logic         capture_o,
  output logic         pc_inc_o,
  output logic         pc_redirect_o,
  output logic         pc_target_o,
  output logic         target_load_o
);

  fetch_state_t state_q, state_d;
  logic         kill_q, kill_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    kill_d        = kill_q;
    capture_o     = 1'b0;
    pc_inc_o      = 1'b0;
    pc_redirect_o = 1'b0;
    pc_target_o   = 1'b0;
    target_load_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        // The outstanding address must not move, so a redirect without an
        // ack is parked in the target register until the ack retires it.
        if (redirect_i && imem_ack_i) begin
          pc_redirect_o = 1'b1;
          kill_d        = 1'b0;
        end else if (redirect_i) begin
          target_load_o = 1'b1;
          kill_d        = 1'b1;
        end else if (imem_ack_i && kill_q) begin
          pc_target_o = 1'b1;
          kill_d      = 1'b0;
        end else if (imem_ack_i) begin
          capture_o = 1'b1;
          state_d   = HOLD;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          pc_redirect_o = 1'b1;
          state_d       = REQ;
        end else if (instr_ready_i) begin
          pc_inc_o = 1'b1;
          state_d  = REQ;
        end
      end

      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  assign state_o = state_q;

endmodule : fetch_fsm

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: owns the pc, issues imem word requests and
// hands captured instructions to decode over a valid/ready handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [N-1:0]       redirect_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [N-1:0]       pc_out
);

  fetch_state_t state;
  logic         capture;
  logic         pc_inc;
  logic         pc_redirect;
  logic         pc_target;
  logic         target_load;

  logic [N-1:0]       pc_q, pc_d;
  logic [N-1:0]       target_q, target_d;
  logic [N-1:0]       pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [N-1:0]       pc_plus4;

  fetch_fsm u_fsm (
    .clk           (clk),
    .reset         (reset),
    .imem_ack_i    (imem_ack),
    .redirect_i    (redirect),
    .instr_ready_i (instr_ready),
    .state_o       (state),
    .capture_o     (capture),
    .pc_inc_o      (pc_inc),
    .pc_redirect_o (pc_redirect),
    .pc_target_o   (pc_target),
    .target_load_o (target_load)
  );

  // Modulo 2^N by truncation, so the top word wraps to address 0.
  assign pc_plus4 = pc_q + N'(PC_INC);

  always_comb begin
    pc_d     = pc_q;
    target_d = target_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;

    if (pc_redirect) begin
      pc_d = redirect_target;
    end else if (pc_target) begin
      pc_d = target_q;
    end else if (pc_inc) begin
      pc_d = pc_plus4;
    end

    if (target_load) begin
      target_d = redirect_target;
    end

    if (capture) begin
      instr_d  = imem_rdata;
      pc_out_d = pc_q;
    end
  end

  // Valid is only ever cleared by leaving HOLD, which is an accept or a redirect.
  assign valid_d = capture | (valid_q & ~(pc_inc | pc_redirect));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      target_q <= '0;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      target_q <= target_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req    = (state == REQ);
  // Address bus reads as zero until the first request, whatever RESET_PC is.
  assign imem_addr   = (state == IDLE) ? '0 : pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing scenarios plus a
// randomized run scored against an architectural next-pc model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_target = '0;
  logic        instr_ready = 1'b0;

  logic        req0, valid0, req1, valid1;
  logic [63:0] addr0, pcout0, addr1, pcout1;
  logic [31:0] instr0, instr1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.N(64), .RESET_PC(64'h0)) dut0 (
    .clk(clk), .reset(reset),
    .imem_req(req0), .imem_addr(addr0), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_target(redirect_target),
    .instr_valid(valid0), .instr_ready(instr_ready), .instr_out(instr0), .pc_out(pcout0)
  );

  fetch_unit #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_target(redirect_target),
    .instr_valid(valid1), .instr_ready(instr_ready), .instr_out(instr1), .pc_out(pcout1)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h8B00_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    redirect = 1'b0;
    redirect_target = '0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] addrs[$];
    logic [63:0] addrs1[$];
    logic [63:0] exp_addr[3];
    logic [63:0] exp_addr1[3];
    logic [63:0] arch, addr_p, tgt;
    logic [31:0] held_instr;
    logic [63:0] held_pc;
    logic        req_p, ack_p, valid_p, rdy, rd, ak;
    int          vfirst, vcount, reqc, accepts;

    // Reset values while reset is held.
    @(negedge clk);
    chk("rst_req", req0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_instr", instr0, 0);
    chk("rst_pcout", pcout0, 0);
    chk("rst_addr_wrapdut", addr1, 0);

    // Zero-wait memory, decode always ready.
    do_reset();
    instr_ready = 1'b1;
    vfirst = -1;
    vcount = 0;
    for (int k = 1; k <= 6; k++) begin
      imem_ack = req0;
      imem_rdata = mem_word(addr0);
      tick();
      if (req0) addrs.push_back(addr0);
      if (req1) addrs1.push_back(addr1);
      if (valid0) begin
        vcount++;
        if (vfirst < 0) begin
          vfirst = k;
          chk("zw_first_pc", pcout0, 64'h0);
          chk("zw_first_instr", instr0, 32'h8B00_0000);
        end
      end
    end
    imem_ack = 1'b0;
    exp_addr  = '{64'h0, 64'h4, 64'h8};
    exp_addr1 = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
    chk("zw_valid_rise_cycle", vfirst, 2);
    chk("zw_valid_count", vcount, 3);
    chk("zw_req_count", addrs.size(), 3);
    for (int i = 0; i < addrs.size() && i < 3; i++) chk("zw_addr_seq", addrs[i], exp_addr[i]);
    chk("wrap_req_count", addrs1.size(), 3);
    for (int i = 0; i < addrs1.size() && i < 3; i++) chk("wrap_addr_seq", addrs1[i], exp_addr1[i]);

    // Three-cycle memory latency, then a four-cycle decode stall.
    do_reset();
    tick();
    reqc = 0;
    for (int k = 0; k < 10 && !valid0; k++) begin
      if (req0) begin
        reqc++;
        chk("lat_addr", addr0, 64'h0);
      end
      imem_ack = req0 && (reqc == 3);
      imem_rdata = mem_word(addr0);
      tick();
    end
    imem_ack = 1'b0;
    chk("lat_req_cycles", reqc, 3);
    chk("lat_valid", valid0, 1);
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", valid0, 1);
      chk("stall_req", req0, 0);
      chk("stall_pcout", pcout0, 64'h0);
      chk("stall_instr", instr0, mem_word(64'h0));
      tick();
    end
    chk("stall_still_valid", valid0, 1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("stall_release_req", req0, 1);
    chk("stall_release_addr", addr0, 64'h4);
    chk("stall_release_valid", valid0, 0);

    // Redirect scenarios from a zero-wait start.
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      imem_ack = req0;
      imem_rdata = mem_word(addr0);
      tick();
    end
    chk("rd_pre_req", req0, 1);
    chk("rd_pre_addr", addr0, 64'h8);
    imem_ack = 1'b0;
    redirect = 1'b1;
    redirect_target = 64'h100;
    tick();
    redirect = 1'b0;
    chk("rd_req_addr_stable", addr0, 64'h8);
    imem_ack = 1'b1;
    imem_rdata = mem_word(addr0);
    tick();
    chk("rd_stale_dropped", valid0, 0);
    chk("rd_new_req", req0, 1);
    chk("rd_new_addr", addr0, 64'h100);
    imem_rdata = mem_word(addr0);
    tick();
    imem_ack = 1'b0;
    chk("rd_new_valid", valid0, 1);
    chk("rd_new_pcout", pcout0, 64'h100);
    chk("rd_new_instr", instr0, mem_word(64'h100));

    redirect = 1'b1;
    redirect_target = 64'h40;
    tick();
    redirect = 1'b0;
    chk("rdh_dropped", valid0, 0);
    chk("rdh_req_addr", addr0, 64'h40);
    imem_ack = 1'b1;
    imem_rdata = mem_word(addr0);
    tick();
    imem_ack = 1'b0;
    chk("rdh_valid", valid0, 1);
    chk("rdh_pcout", pcout0, 64'h40);

    tick();
    chk("rd2_req_addr", addr0, 64'h44);
    redirect = 1'b1;
    redirect_target = 64'h200;
    tick();
    redirect_target = 64'h300;
    tick();
    redirect = 1'b0;
    chk("rd2_addr_stable", addr0, 64'h44);
    imem_ack = 1'b1;
    imem_rdata = mem_word(addr0);
    tick();
    imem_ack = 1'b0;
    chk("rd2_stale_dropped", valid0, 0);
    chk("rd2_latest_wins", addr0, 64'h300);
    tick();
    chk("rd2_addr_hold", addr0, 64'h300);
    imem_ack = 1'b1;
    imem_rdata = mem_word(addr0);
    tick();
    imem_ack = 1'b0;
    chk("rd2_valid", valid0, 1);
    chk("rd2_pcout", pcout0, 64'h300);

    // Asynchronous reset in the middle of a request, with a late ack.
    tick();
    chk("ar_pre_req", req0, 1);
    #2;
    reset = 1'b1;
    imem_ack = 1'b1;
    #1;
    chk("ar_req_dropped", req0, 0);
    chk("ar_addr_zero", addr0, 0);
    chk("ar_valid_zero", valid0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("ar_late_ack_valid", valid0, 0);
    chk("ar_late_ack_req", req0, 0);
    imem_ack = 1'b0;

    // Randomized run against an architectural next-pc model.
    do_reset();
    tick();
    arch = 64'h0;
    addr_p = '0;
    req_p = 1'b0;
    ack_p = 1'b0;
    valid_p = 1'b0;
    accepts = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_excl", req0 & valid0, 0);
      if (req0 && (!req_p || ack_p)) chk("rnd_new_addr", addr0, arch);
      else if (req0) chk("rnd_addr_hold", addr0, addr_p);
      if (valid0) begin
        chk("rnd_pcout", pcout0, arch);
        chk("rnd_instr", instr0, mem_word(arch));
        if (!valid_p) chk("rnd_valid_after_ack", ack_p, 1);
      end

      ak = req0 && ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 11) == 0);
      tgt = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 1) == 1);
      imem_ack = ak;
      imem_rdata = mem_word(addr0);
      redirect = rd;
      redirect_target = tgt;
      instr_ready = rdy;

      if (valid0 && rdy && !rd) accepts++;
      if (rd) arch = tgt;
      else if (valid0 && rdy) arch = arch + 64'd4;
      req_p = req0;
      ack_p = ak;
      addr_p = addr0;
      valid_p = valid0;
      tick();
    end
    chk("rnd_accepts_min", accepts >= 100, 1);

    // Asynchronous reset while an instruction is held.
    redirect = 1'b0;
    instr_ready = 1'b0;
    for (int k = 0; k < 20 && !valid0; k++) begin
      imem_ack = req0;
      imem_rdata = mem_word(addr0);
      tick();
    end
    imem_ack = 1'b0;
    chk("arh_pre_valid", valid0, 1);
    held_instr = instr0;
    held_pc = pcout0;
    tick();
    chk("arh_hold_instr", instr0, held_instr);
    chk("arh_hold_pc", pcout0, held_pc);
    #2;
    reset = 1'b1;
    #1;
    chk("arh_valid_dropped", valid0, 0);
    chk("arh_pcout_zero", pcout0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the LEGv8 core. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. It captures each returned instruction and presents it to decode with a valid/ready handshake. It accepts branch redirects from execute at any time and discards any fetch that a redirect makes stale.

## Interface
Parameters:
- N, 64, PC/address width
- RESET_PC, 64'h0, PC value loaded by reset

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  memory request; held high until ack
- imem_addr  out  N  request address; stable while imem_req=1
- imem_ack  in  1  one-cycle pulse: imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- redirect  in  1  one-cycle pulse: fetch must restart at redirect_target
- redirect_target  in  N  new PC, sampled only when redirect=1
- instr_valid  out  1  instr_out/pc_out hold a fetched instruction
- instr_ready  in  1  decode accepts the instruction this cycle
- instr_out  out  32  fetched instruction
- pc_out  out  N  address instr_out was fetched from

## Operation
- States: IDLE, REQ, HOLD. The FSM also keeps a kill flag and a target register.
- IDLE:
  - This is the reset state; all outputs are 0.
  - First posedge with reset=0 → REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack with kill=0: instr_out←imem_rdata, pc_out←pc, go to HOLD.
  - On imem_ack with kill=1: data is dropped, pc←target, kill←0, stay in REQ. A new request issues next cycle.
  - Without ack, stay in REQ.
- HOLD:
  - instr_valid=1, imem_req=0.
  - On instr_ready=1: pc←pc+4, go to REQ.
  - Otherwise hold all outputs stable.
- Redirect:
  - In REQ, the address cannot change mid-request. The FSM sets kill=1 and target←redirect_target.
  - In HOLD, the held instruction is dropped even if instr_ready=1 that cycle. pc←redirect_target, instr_valid→0, go to REQ.
  - In IDLE, redirect is ignored.
  - Redirect in the same cycle as imem_ack in REQ: the ack data is dropped, pc←redirect_target, stay in REQ.
  - Redirect while kill=1 already set: target is overwritten, so the latest redirect wins.
- Arithmetic:
  - pc+4 is modulo 2^N; 2^N−4 wraps to 0.
  - redirect_target is used unmodified; no alignment check.

## Timing
- Reset values: imem_req=0, imem_addr=0, instr_valid=0, instr_out=0, pc_out=0, pc=RESET_PC, kill=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-request drops imem_req immediately, and any late ack is ignored.
- First request: imem_req rises in the cycle after the first posedge with reset low.
- Zero-wait memory (ack in first REQ cycle): instr_valid rises 1 cycle after imem_req rises.
- Steady-state throughput with zero-wait memory and instr_ready tied high is one instruction per 2 cycles.
- Redirect penalty with zero-wait memory: new-target request appears the cycle after redirect; its instruction is valid one cycle later.
- Outputs are registered, except imem_addr, which equals the pc register, and imem_req, which is decoded from state.

## Structure
- Package fetch_pkg holds:
  - enum fetch_state_t {IDLE, REQ, HOLD}
  - localparam INSTR_W=32
  - localparam PC_INC=4
- One sub-module, fetch_fsm: state register, kill flag and next-state logic.
- The top level holds the pc, target and output registers, plus the pc+4 adder.
- The existing flopr is not used for pc, because its reset value is fixed at 0 while this block needs RESET_PC.

## Test plan
- Reset, then zero-wait memory returning 32'h8B000000 at addr 0 with instr_ready=1:
  - imem_addr sequence is 0, 4, 8.
  - instr_valid rises 2 cycles after reset deassert, with pc_out=0 and instr_out=32'h8B000000.
- 3-cycle memory latency, instr_ready=0 for 4 cycles in HOLD:
  - imem_req stays high 3 cycles.
  - instr_out and pc_out are stable while stalled.
  - pc advances to 4 only after instr_ready=1.
- Redirect to 64'h100 during a pending REQ at addr 8:
  - The ack for addr 8 is discarded and instr_valid never rises for it.
  - The next imem_addr is 64'h100.
- Redirect to 64'h40 in HOLD together with instr_ready=1:
  - The held instruction is dropped.
  - Next request is at 64'h40; pc_out of the next valid instruction is 64'h40.
- Two redirects, to 64'h200 then 64'h300, within one pending request:
  - The only subsequent request is at 64'h300.
- Wrap and reset:
  - With RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, the second imem_addr is 0.
  - Asserting reset mid-REQ drops imem_req and instr_valid asynchronously to 0.
